// File: rtl/iomem_arbiter.sv
// Two-requester round-robin arbiter sharing one PicoSoC iomem slave port.
// Optional slave-timeout watchdog enabled by defining IOMEM_ARB_TIMEOUT_EN.
module iomem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    input  logic        m1_valid,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m_rdata,
    output logic        s_valid,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t state;
    logic   last_grant;   // owner of the current or most recent transaction
    logic   next_owner;

    // On a tie the requester that did not win last time is served.
    assign next_owner = (m0_valid && m1_valid) ? !last_grant : m1_valid;

    assign s_valid = (state == BUSY);
    assign s_wstrb = last_grant ? m1_wstrb : m0_wstrb;
    assign s_addr  = last_grant ? m1_addr  : m0_addr;
    assign s_wdata = last_grant ? m1_wdata : m0_wdata;
    assign grant   = (state == IDLE) ? 2'b00 : (last_grant ? 2'b10 : 2'b01);

`ifdef IOMEM_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] counter;
    logic        timeout_q;
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    // NOTE: all state here is sequential, so every assignment uses <=; a blocking
    // assignment would let later statements in this block see the new value early.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            m_rdata    <= 32'h0;
            m0_ready   <= 1'b0;
            m1_ready   <= 1'b0;
`ifdef IOMEM_ARB_TIMEOUT_EN
            counter    <= 16'h0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
`ifdef IOMEM_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        last_grant <= next_owner;
                        state      <= BUSY;
`ifdef IOMEM_ARB_TIMEOUT_EN
                        counter    <= 16'h0;
`endif
                    end
                end
                BUSY: begin
                    if (s_ready) begin
                        m_rdata  <= s_rdata;
                        m0_ready <= !last_grant;
                        m1_ready <= last_grant;
                        state    <= RESP;
                    end
`ifdef IOMEM_ARB_TIMEOUT_EN
                    else if (counter == TIMEOUT_LAST) begin
                        m_rdata   <= TIMEOUT_RDATA;
                        m0_ready  <= !last_grant;
                        m1_ready  <= last_grant;
                        timeout_q <= 1'b1;
                        state     <= RESP;
                    end else if (counter != 16'hFFFF) begin
                        counter <= counter + 16'd1;
                    end
`endif
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
